// File: rtl/tt_sweep.sv
// tt_sweep: exhaustive truth-table sweep of an N-input function under test.
// Each input vector is held for HOLD cycles, then F is captured into TABLE.
// After the last vector, PASS reports whether TABLE matches EXPECT.
module tt_sweep #(
   parameter int unsigned N    = 5,
   parameter int unsigned HOLD = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic                  F,
   input  logic [(1 << N)-1:0]   EXPECT,
   output logic [N-1:0]          X,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [(1 << N)-1:0]   TABLE,
   output logic [N:0]            ONES,
   output logic                  PASS
);

   localparam int unsigned TW = 1 << N;
   localparam int unsigned OW = N + 1;
   localparam int unsigned CW = 8;
   localparam logic [N-1:0]  X_LAST   = N'(TW - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   x_q, x_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [TW-1:0]  table_q, table_d;
   logic [OW-1:0]  ones_q, ones_d;
   logic           pass_q, pass_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   // Next-state and next-output computation for the sweep sequencer.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      ones_d  = ones_q;
      pass_d  = pass_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            x_d = '0;
            if (START) begin
               state_d = S_DRIVE;
               cnt_d   = '0;
               table_d = '0;
               ones_d  = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_DRIVE: begin
            busy_d = 1'b1;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               // Sample point: capture F for the vector currently driven.
               cnt_d        = '0;
               table_d[x_q] = F;
               ones_d       = ones_q + OW'(F);
               if (x_q == X_LAST) begin
                  // X stays at the last vector; it returns to 0 in IDLE.
                  state_d = S_FINISH;
                  pass_d  = (table_d == EXPECT);
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  x_d = x_q + N'(1);
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            x_d     = '0;
         end
         default: begin
            state_d = S_IDLE;
            x_d     = '0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         cnt_q   <= '0;
         table_q <= '0;
         ones_q  <= '0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         ones_q  <= ones_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign X     = x_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;
   assign TABLE = table_q;
   assign ONES  = ones_q;
   assign PASS  = pass_q;

endmodule

// File: tb/tb_tt_sweep.sv
// tb_tt_sweep: randomized self-checking bench for tt_sweep.
// Three instances: N=5/HOLD=1, N=5/HOLD=3, N=3/HOLD=2.
module tb_tt_sweep;

   logic clk;
   logic rst;

   // Instance 0: N=5, HOLD=1; F comes from a bench-owned truth table.
   logic        start0;
   logic [31:0] ftab0, expect0, table0;
   logic [4:0]  x0;
   logic [5:0]  ones0;
   logic        f0, busy0, done0, pass0;

   // Instance 1: N=5, HOLD=3; F = X[4] & X[3].
   logic        start1;
   logic [31:0] expect1, table1;
   logic [4:0]  x1;
   logic [5:0]  ones1;
   logic        f1, busy1, done1, pass1;

   // Instance 2: N=3, HOLD=2; F from a bench-owned truth table.
   logic        start2;
   logic [7:0]  ftab2, expect2, table2;
   logic [2:0]  x2;
   logic [3:0]  ones2;
   logic        f2, busy2, done2, pass2;

   int checks = 0;
   int errors = 0;

   assign f0 = ftab0[x0];
   assign f1 = x1[4] & x1[3];
   assign f2 = ftab2[x2];

   tt_sweep #(.N(5), .HOLD(1)) u0 (
      .CLK(clk), .RST(rst), .START(start0), .F(f0), .EXPECT(expect0),
      .X(x0), .BUSY(busy0), .DONE(done0), .TABLE(table0), .ONES(ones0), .PASS(pass0));

   tt_sweep #(.N(5), .HOLD(3)) u1 (
      .CLK(clk), .RST(rst), .START(start1), .F(f1), .EXPECT(expect1),
      .X(x1), .BUSY(busy1), .DONE(done1), .TABLE(table1), .ONES(ones1), .PASS(pass1));

   tt_sweep #(.N(3), .HOLD(2)) u2 (
      .CLK(clk), .RST(rst), .START(start2), .F(f2), .EXPECT(expect2),
      .X(x2), .BUSY(busy2), .DONE(done2), .TABLE(table2), .ONES(ones2), .PASS(pass2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse START on instance 0 and count edges until DONE (-1 on timeout).
   task automatic sweep0(output int lat);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      lat = 0;
      while (done0 !== 1'b1 && lat < 400) begin
         tick();
         lat++;
      end
      if (done0 !== 1'b1) lat = -1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if ({x0, busy0, done0, table0, ones0, pass0} !== '0) begin
         errors++;
         $display("FAIL reset_u0 got x=%0d busy=%b done=%b table=%h ones=%0d pass=%b",
                  x0, busy0, done0, table0, ones0, pass0);
      end
      checks++;
      if ({x1, busy1, done1, table1, ones1, pass1} !== '0) begin
         errors++;
         $display("FAIL reset_u1 got x=%0d busy=%b done=%b table=%h ones=%0d pass=%b",
                  x1, busy1, done1, table1, ones1, pass1);
      end
      checks++;
      if ({x2, busy2, done2, table2, ones2, pass2} !== '0) begin
         errors++;
         $display("FAIL reset_u2 got x=%0d busy=%b done=%b table=%h ones=%0d pass=%b",
                  x2, busy2, done2, table2, ones2, pass2);
      end
      rst = 1'b0;
      tick();
      tick();
   endtask

   // F = X[0], EXPECT matches: latency, X ramp, BUSY and results.
   task automatic test_basic();
      int e;
      ftab0   = 32'hAAAA_AAAA;
      expect0 = 32'hAAAA_AAAA;
      start0  = 1'b1;
      tick();
      start0  = 1'b0;
      e = 0;
      while (done0 !== 1'b1 && e < 400) begin
         checks++;
         if (x0 !== 5'(e) || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_ramp edge=%0d got x=%0d busy=%b want x=%0d busy=1",
                     e, x0, busy0, e);
         end
         tick();
         e++;
      end
      checks++;
      if (e !== 32) begin
         errors++;
         $display("FAIL basic_latency got %0d edges want 32", e);
      end
      checks++;
      if (busy0 !== 1'b0 || table0 !== 32'hAAAA_AAAA || ones0 !== 6'd16 || pass0 !== 1'b1) begin
         errors++;
         $display("FAIL basic_result got busy=%b table=%h ones=%0d pass=%b want 0 aaaaaaaa 16 1",
                  busy0, table0, ones0, pass0);
      end
      tick();
      checks++;
      if (done0 !== 1'b0 || x0 !== 5'd0 || busy0 !== 1'b0 || table0 !== 32'hAAAA_AAAA) begin
         errors++;
         $display("FAIL basic_idle got done=%b x=%0d busy=%b table=%h want 0 0 0 aaaaaaaa",
                  done0, x0, busy0, table0);
      end
   endtask

   // Random truth tables, EXPECT either equal or off by one bit.
   task automatic test_random();
      int lat;
      logic [31:0] want_tab;
      logic        want_pass;
      for (int r = 0; r < 6; r++) begin
         ftab0 = $urandom;
         if ((r % 2) == 0) expect0 = ftab0;
         else expect0 = ftab0 ^ (32'h1 << $urandom_range(0, 31));
         want_tab  = ftab0;
         want_pass = (want_tab == expect0);
         sweep0(lat);
         checks++;
         if (lat !== 32) begin
            errors++;
            $display("FAIL random_latency run=%0d got %0d want 32", r, lat);
         end
         checks++;
         if (table0 !== want_tab || ones0 !== 6'($countones(want_tab)) || pass0 !== want_pass) begin
            errors++;
            $display("FAIL random_result run=%0d got table=%h ones=%0d pass=%b want %h %0d %b",
                     r, table0, ones0, pass0, want_tab, $countones(want_tab), want_pass);
         end
      end
   endtask

   // F = 1 everywhere: ONES must reach 32 without wrapping.
   task automatic test_all_ones();
      int lat;
      ftab0   = 32'hFFFF_FFFF;
      expect0 = 32'hFFFF_FFFF;
      sweep0(lat);
      checks++;
      if (lat !== 32 || table0 !== 32'hFFFF_FFFF || ones0 !== 6'd32 || pass0 !== 1'b1) begin
         errors++;
         $display("FAIL all_ones got lat=%0d table=%h ones=%0d pass=%b want 32 ffffffff 32 1",
                  lat, table0, ones0, pass0);
      end
      ftab0   = 32'h0;
      expect0 = 32'h0;
      sweep0(lat);
      checks++;
      if (table0 !== 32'h0 || ones0 !== 6'd0 || pass0 !== 1'b1) begin
         errors++;
         $display("FAIL all_zeros got table=%h ones=%0d pass=%b want 0 0 1",
                  table0, ones0, pass0);
      end
   endtask

   // START pulsed at X=10 mid-sweep must not restart or queue anything.
   task automatic test_start_ignored();
      int e;
      int dones;
      int first;
      bit pulsed;
      ftab0   = $urandom;
      expect0 = ftab0;
      start0  = 1'b1;
      tick();
      start0  = 1'b0;
      e = 0;
      dones = 0;
      first = -1;
      pulsed = 0;
      while (e < 80) begin
         if (done0 === 1'b1) begin
            dones++;
            if (first < 0) first = e;
         end
         if (!pulsed && x0 === 5'd10 && busy0 === 1'b1) begin
            start0 = 1'b1;
            pulsed = 1;
         end else begin
            start0 = 1'b0;
         end
         tick();
         e++;
      end
      start0 = 1'b0;
      checks++;
      if (first !== 32 || dones !== 1) begin
         errors++;
         $display("FAIL start_ignored got first_done=%0d pulses=%0d want 32 1", first, dones);
      end
      checks++;
      if (busy0 !== 1'b0 || table0 !== ftab0 || pass0 !== 1'b1) begin
         errors++;
         $display("FAIL start_ignored_result got busy=%b table=%h pass=%b want 0 %h 1",
                  busy0, table0, pass0, ftab0);
      end
   endtask

   // EXPECT matters only on the final-sample edge.
   task automatic test_expect_late();
      int e;
      ftab0   = $urandom;
      expect0 = ~ftab0;
      start0  = 1'b1;
      tick();
      start0  = 1'b0;
      e = 0;
      while (x0 !== 5'd31 && e < 100) begin
         tick();
         e++;
      end
      expect0 = ftab0;
      tick();
      checks++;
      if (done0 !== 1'b1 || pass0 !== 1'b1) begin
         errors++;
         $display("FAIL expect_late got done=%b pass=%b want 1 1", done0, pass0);
      end
      expect0 = ~ftab0;
      tick();
      tick();
      tick();
      checks++;
      if (pass0 !== 1'b1 || table0 !== ftab0) begin
         errors++;
         $display("FAIL expect_hold got pass=%b table=%h want 1 %h", pass0, table0, ftab0);
      end
   endtask

   // Asynchronous reset at X=7 aborts the sweep with no DONE.
   task automatic test_reset_mid();
      int e;
      int dones;
      int lat;
      ftab0   = 32'hFFFF_FFFF;
      expect0 = 32'hFFFF_FFFF;
      start0  = 1'b1;
      tick();
      start0  = 1'b0;
      e = 0;
      while (x0 !== 5'd7 && e < 100) begin
         tick();
         e++;
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({x0, busy0, done0, table0, ones0, pass0} !== '0) begin
         errors++;
         $display("FAIL reset_mid got x=%0d busy=%b done=%b table=%h ones=%0d pass=%b want all 0",
                  x0, busy0, done0, table0, ones0, pass0);
      end
      #1;
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (done0 === 1'b1 || busy0 === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL reset_no_resume got %0d active cycles want 0", dones);
      end
      ftab0   = $urandom;
      expect0 = ftab0;
      sweep0(lat);
      checks++;
      if (lat !== 32 || table0 !== ftab0 || ones0 !== 6'($countones(ftab0)) || pass0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_then_sweep got lat=%0d table=%h ones=%0d pass=%b want 32 %h %0d 1",
                  lat, table0, ones0, pass0, ftab0, $countones(ftab0));
      end
   endtask

   // HOLD=3 with F = X[4] & X[3]: each vector held three cycles.
   task automatic test_hold3();
      int e;
      logic [31:0] want_tab;
      for (int i = 0; i < 32; i++) want_tab[i] = (i >= 24);
      expect1 = 32'h0;
      start1  = 1'b1;
      tick();
      start1  = 1'b0;
      e = 0;
      while (done1 !== 1'b1 && e < 400) begin
         checks++;
         if (x1 !== 5'(e / 3) || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL hold3_ramp edge=%0d got x=%0d busy=%b want x=%0d busy=1",
                     e, x1, busy1, e / 3);
         end
         tick();
         e++;
      end
      checks++;
      if (e !== 96) begin
         errors++;
         $display("FAIL hold3_latency got %0d edges want 96", e);
      end
      checks++;
      if (table1 !== want_tab || ones1 !== 6'($countones(want_tab)) || pass1 !== 1'b0) begin
         errors++;
         $display("FAIL hold3_result got table=%h ones=%0d pass=%b want %h %0d 0",
                  table1, ones1, pass1, want_tab, $countones(want_tab));
      end
      tick();
   endtask

   // START held high on N=3/HOLD=2: back-to-back sweeps, one IDLE cycle apart.
   task automatic test_back_to_back();
      int e;
      logic [7:0] cur_tab;
      ftab2   = 8'($urandom);
      expect2 = ftab2;
      start2  = 1'b1;
      tick();
      for (int s = 0; s < 3; s++) begin
         cur_tab = ftab2;
         e = 0;
         while (done2 !== 1'b1 && e < 100) begin
            checks++;
            if (x2 !== 3'(e / 2) || busy2 !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ramp sweep=%0d edge=%0d got x=%0d busy=%b want x=%0d busy=1",
                        s, e, x2, busy2, e / 2);
            end
            tick();
            e++;
         end
         checks++;
         if (e !== 16) begin
            errors++;
            $display("FAIL b2b_latency sweep=%0d got %0d edges want 16", s, e);
         end
         checks++;
         if (table2 !== cur_tab || ones2 !== 4'($countones(cur_tab)) || pass2 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result sweep=%0d got table=%h ones=%0d pass=%b want %h %0d 1",
                     s, table2, ones2, pass2, cur_tab, $countones(cur_tab));
         end
         ftab2   = 8'($urandom);
         expect2 = ftab2;
         if (s == 2) start2 = 1'b0;
         tick();
         checks++;
         if (busy2 !== 1'b0 || done2 !== 1'b0 || x2 !== 3'd0) begin
            errors++;
            $display("FAIL b2b_idle sweep=%0d got busy=%b done=%b x=%0d want 0 0 0",
                     s, busy2, done2, x2);
         end
         tick();
      end
      tick();
      checks++;
      if (busy2 !== 1'b0 || done2 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stop got busy=%b done=%b want 0 0", busy2, done2);
      end
   endtask

   initial begin
      rst     = 1'b1;
      start0  = 1'b0;
      start1  = 1'b0;
      start2  = 1'b0;
      ftab0   = '0;
      expect0 = '0;
      expect1 = '0;
      ftab2   = '0;
      expect2 = '0;
      test_reset();
      test_basic();
      test_random();
      test_all_ones();
      test_start_ignored();
      test_expect_late();
      test_reset_mid();
      test_hold3();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 Parameter N, default 5, number of stimulus inputs (2..10).
REQ-002 Parameter HOLD, default 1, clock cycles each input vector is held before F is sampled (1..255).
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  sweep request; sampled on the rising edge of CLK.
REQ-006 F  input  1  response of the function under test to X.
REQ-007 EXPECT  input  2^N  expected truth table, bit i = expected F for X=i.
REQ-008 X  output  N  current stimulus vector driven to the function under test.
REQ-009 BUSY  output  1  high while a sweep is in progress.
REQ-010 DONE  output  1  one-cycle pulse marking sweep completion.
REQ-011 TABLE  output  2^N  captured truth table, bit i = F sampled for X=i.
REQ-012 ONES  output  N+1  number of vectors with F=1 in the last sweep.
REQ-013 PASS  output  1  high when the captured TABLE equals EXPECT.

Function
REQ-014 The block SHALL implement three states: IDLE, DRIVE and FINISH; all outputs are registered.
REQ-015 IDLE: BUSY=0, DONE=0, X=0; TABLE, ONES and PASS hold their last values.
REQ-016 IDLE and START=1 at an edge: next state DRIVE, X=0, hold counter=0, TABLE=0, ONES=0, PASS=0, BUSY=1.
REQ-017 DRIVE: the hold counter SHALL increment each cycle; the terminal cycle is hold counter = HOLD-1.
REQ-018 Terminal cycle of DRIVE: TABLE[X] <= F, ONES <= ONES+F, hold counter <= 0.
REQ-019 Terminal cycle with X < 2^N-1: X <= X+1 and the block stays in DRIVE.
REQ-020 Terminal cycle with X = 2^N-1: next state FINISH; on the same edge, PASS <= (final TABLE including this sample == EXPECT).
REQ-021 FINISH SHALL last exactly one cycle with DONE=1 and BUSY=0, then return to IDLE with X=0.
REQ-022 Latency: when START is sampled at edge k, DONE SHALL be high during the cycle following edge k + 2^N*HOLD.
REQ-023 START asserted while in DRIVE or FINISH SHALL be ignored; it SHALL not restart, extend or queue a sweep.
REQ-024 START held continuously high SHALL begin a new sweep at the first edge in IDLE after FINISH, i.e. back-to-back sweeps with one IDLE cycle between them.
REQ-025 ONES SHALL not saturate or wrap; N+1 bits cover the maximum value 2^N.
REQ-026 X SHALL not wrap within a sweep; the next sweep always begins at 0.
REQ-027 EXPECT SHALL be sampled only on the final-sample edge; changes at any other time have no effect.

Reset
REQ-028 RST=1 SHALL force state IDLE immediately, without waiting for CLK.
REQ-029 RST=1 SHALL force X=0, BUSY=0, DONE=0, TABLE=0, ONES=0, PASS=0 and hold counter=0.
REQ-030 RST asserted mid-sweep SHALL abort the sweep with no DONE pulse; after release, only a new START begins a sweep.

Verification (N=5 unless stated)
REQ-031 HOLD=1, F=X[0], EXPECT=32'hAAAAAAAA, single START pulse -> DONE high exactly 33 cycles after the START edge; TABLE=32'hAAAAAAAA, ONES=16, PASS=1.
REQ-032 HOLD=3, F=X[4]&X[3], EXPECT=0 -> each X value held 3 cycles; DONE high 97 cycles after START; TABLE=32'hFF000000, ONES=8, PASS=0.
REQ-033 HOLD=1, F=1 -> TABLE=32'hFFFFFFFF, ONES=6'd32 with no wrap.
REQ-034 START pulsed again at X=10 during a sweep -> sweep continues unchanged; exactly one DONE pulse at cycle 33.
REQ-035 RST pulsed asynchronously between edges at X=7 -> all outputs 0 immediately and no DONE pulse; a new START then completes a normal sweep.
REQ-036 N=3, HOLD=2, START held high -> DONE pulses every 18 cycles; X sequence 0..7 with each value held 2 cycles.
